// File: rtl/echo_seq_pkg.sv
// Shared types and constants for the echo frame sequencer: state codes, error
// stage codes and the IEEE-754 double container.
package echo_seq_pkg;

  typedef logic [2:0] state_t;

  // Encoding order matters: each *_P is followed by its *_W, so the sequencer
  // advances with state + 1.
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CONV_P  = 3'd1;
  localparam state_t ST_CONV_W  = 3'd2;
  localparam state_t ST_LAG_P   = 3'd3;
  localparam state_t ST_LAG_W   = 3'd4;
  localparam state_t ST_BR_P    = 3'd5;
  localparam state_t ST_BR_W    = 3'd6;
  localparam state_t ST_DELIVER = 3'd7;

  typedef logic [1:0] stage_t;

  localparam stage_t ERR_CONV = 2'd0;
  localparam stage_t ERR_LAG  = 2'd1;
  localparam stage_t ERR_BR   = 2'd2;
  localparam stage_t ERR_OVR  = 2'd3;

  typedef logic [63:0] double_t;

  function automatic stage_t stage_of(input state_t s);
    case (s)
      ST_CONV_P, ST_CONV_W: stage_of = ERR_CONV;
      ST_LAG_P, ST_LAG_W:   stage_of = ERR_LAG;
      default:              stage_of = ERR_BR;
    endcase
  endfunction

endpackage

// File: rtl/seq_stage_timer.sv
// Shared per-stage timing: enable pulse length, wait counter with timeout and
// the armed flag that rejects a ready left high from an earlier frame.
module seq_stage_timer #(
  parameter int PULSE_LEN = 2,
  parameter int WAIT_W    = 10
) (
  input  logic              clk_operation,
  input  logic              rst,
  input  logic              start_pulse,
  input  logic              start_wait,
  input  logic              in_pulse,
  input  logic              in_wait,
  input  logic              ready,
  input  logic [WAIT_W-1:0] limit,
  output logic              pulse_last,
  output logic              complete,
  output logic              timeout
);

  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);

  logic [PW-1:0]     pulse_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              armed;

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      pulse_cnt <= '0;
      wait_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      if (start_pulse) begin
        pulse_cnt <= '0;
        armed     <= 1'b0;
      end else begin
        if (in_pulse) pulse_cnt <= pulse_cnt + 1'b1;
        if ((in_pulse || in_wait) && !ready) armed <= 1'b1;
      end
      if (start_wait)   wait_cnt <= '0;
      else if (in_wait) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign pulse_last = in_pulse && (pulse_cnt == PULSE_LAST);
  assign complete   = in_wait && armed && ready;
  // Completion wins over timeout when both land on the limit cycle.
  assign timeout    = in_wait && !complete && (wait_cnt == limit);

endmodule

// File: rtl/echo_frame_sequencer.sv
// Sequences one echo-cancellation frame per sampling period: converter, lag
// generator, then approximator or canceller, and delivers the chosen double.
module echo_frame_sequencer
  import echo_seq_pkg::*;
#(
  parameter int CNT_W     = 13,
  parameter int PULSE_LEN = 2,
  parameter int TO_CONV   = 25,
  parameter int TO_LAG    = 200,
  parameter int TO_APPROX = 600,
  parameter int TO_CANCEL = 250
) (
  input  logic             clk_operation,
  input  logic             rst,
  input  logic [CNT_W-1:0] sampling_cycle_counter,
  input  logic             adapt_mode,
  input  logic             ready_conv,
  input  logic             ready_lag,
  input  logic             ready_approx,
  input  logic             ready_cancel,
  input  double_t          e,
  input  double_t          signal_without_echo,
  output logic             enable_conv,
  output logic             enable_lag,
  output logic             enable_approx,
  output logic             enable_cancel,
  output logic             enable_out,
  output double_t          double_out,
  output logic             frame_done,
  output logic             frame_error,
  output stage_t           err_stage,
  output logic [15:0]      frame_count,
  output state_t           state_dbg
);

  localparam int TO_MAX_A = (TO_CONV > TO_LAG) ? TO_CONV : TO_LAG;
  localparam int TO_MAX_B = (TO_APPROX > TO_CANCEL) ? TO_APPROX : TO_CANCEL;
  localparam int TO_MAX   = (TO_MAX_A > TO_MAX_B) ? TO_MAX_A : TO_MAX_B;
  localparam int WAIT_W   = $clog2(TO_MAX + 1);

  state_t            state, state_nxt;
  logic              mode_q;
  logic              frame_start, in_pulse, in_wait;
  logic              start_pulse, start_wait, latch_mode, deliver, fail;
  stage_t            fail_code;
  logic              stage_ready, pulse_last, complete, timeout;
  logic [WAIT_W-1:0] stage_limit;

  assign frame_start = (sampling_cycle_counter == '0);
  assign in_pulse    = state inside {ST_CONV_P, ST_LAG_P, ST_BR_P};
  assign in_wait     = state inside {ST_CONV_W, ST_LAG_W, ST_BR_W};

  always_comb begin
    stage_ready = ready_conv;
    stage_limit = WAIT_W'(TO_CONV);
    case (stage_of(state))
      ERR_LAG: begin
        stage_ready = ready_lag;
        stage_limit = WAIT_W'(TO_LAG);
      end
      ERR_BR: begin
        stage_ready = mode_q ? ready_approx : ready_cancel;
        stage_limit = mode_q ? WAIT_W'(TO_APPROX) : WAIT_W'(TO_CANCEL);
      end
      default: ;
    endcase
  end

  seq_stage_timer #(.PULSE_LEN(PULSE_LEN), .WAIT_W(WAIT_W)) u_timer (
    .clk_operation (clk_operation),
    .rst           (rst),
    .start_pulse   (start_pulse),
    .start_wait    (start_wait),
    .in_pulse      (in_pulse),
    .in_wait       (in_wait),
    .ready         (stage_ready),
    .limit         (stage_limit),
    .pulse_last    (pulse_last),
    .complete      (complete),
    .timeout       (timeout)
  );

  always_comb begin
    state_nxt   = state;
    start_pulse = 1'b0;
    start_wait  = 1'b0;
    latch_mode  = 1'b0;
    deliver     = 1'b0;
    fail        = 1'b0;
    fail_code   = ERR_CONV;
    // A new frame start outside IDLE aborts whatever the old frame was doing.
    if (frame_start && state != ST_IDLE) begin
      state_nxt   = ST_CONV_P;
      start_pulse = 1'b1;
      latch_mode  = 1'b1;
      fail        = 1'b1;
      fail_code   = ERR_OVR;
    end else begin
      case (state)
        ST_IDLE: if (frame_start) begin
          state_nxt   = ST_CONV_P;
          start_pulse = 1'b1;
          latch_mode  = 1'b1;
        end
        ST_CONV_P, ST_LAG_P, ST_BR_P: if (pulse_last) begin
          state_nxt  = state + 3'd1;
          start_wait = 1'b1;
        end
        ST_CONV_W, ST_LAG_W, ST_BR_W: begin
          if (complete) begin
            state_nxt   = state + 3'd1;
            start_pulse = (state != ST_BR_W);
          end else if (timeout) begin
            state_nxt = ST_IDLE;
            fail      = 1'b1;
            fail_code = stage_of(state);
          end
        end
        ST_DELIVER: begin
          state_nxt = ST_IDLE;
          deliver   = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= 1'b0;
      double_out  <= '0;
      enable_out  <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_stage   <= ERR_CONV;
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      frame_done  <= deliver;
      frame_error <= fail;
      if (latch_mode) mode_q <= adapt_mode;
      if (fail) err_stage <= fail_code;
      if (deliver) begin
        double_out  <= mode_q ? e : signal_without_echo;
        enable_out  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  assign enable_conv   = (state == ST_CONV_P);
  assign enable_lag    = (state == ST_LAG_P);
  assign enable_approx = (state == ST_BR_P) && mode_q;
  assign enable_cancel = (state == ST_BR_P) && !mode_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_echo_frame_sequencer.sv
// Directed bench for echo_frame_sequencer: stage responders, an event
// scoreboard with spec-derived latencies, and a per-cycle output model.
module tb_echo_frame_sequencer;
  import echo_seq_pkg::*;

  localparam int CNT_W     = 13;
  localparam int PULSE_LEN = 2;
  localparam int TO_CONV   = 25;
  localparam int TO_LAG    = 200;
  localparam int TO_APPROX = 600;
  localparam int TO_CANCEL = 250;
  localparam int HOLD      = 10;
  // Ready goes low on the first wait cycle and high HOLD cycles later.
  localparam int WAIT_NOM  = HOLD + 1;
  localparam int LAT_NOM   = 1 + 3 * PULSE_LEN + 3 * WAIT_NOM + 1;
  localparam logic [CNT_W-1:0] CNT_RUN = 13'd100;

  logic             clk_operation = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] sampling_cycle_counter;
  logic             adapt_mode;
  logic             ready_conv, ready_lag, ready_approx, ready_cancel;
  logic [63:0]      e, signal_without_echo;
  logic             enable_conv, enable_lag, enable_approx, enable_cancel;
  logic             enable_out, frame_done, frame_error;
  logic [63:0]      double_out;
  logic [1:0]       err_stage;
  logic [15:0]      frame_count;
  logic [2:0]       state_dbg;

  echo_frame_sequencer #(
    .CNT_W(CNT_W), .PULSE_LEN(PULSE_LEN), .TO_CONV(TO_CONV),
    .TO_LAG(TO_LAG), .TO_APPROX(TO_APPROX), .TO_CANCEL(TO_CANCEL)
  ) dut (
    .clk_operation(clk_operation), .rst(rst),
    .sampling_cycle_counter(sampling_cycle_counter), .adapt_mode(adapt_mode),
    .ready_conv(ready_conv), .ready_lag(ready_lag),
    .ready_approx(ready_approx), .ready_cancel(ready_cancel),
    .e(e), .signal_without_echo(signal_without_echo),
    .enable_conv(enable_conv), .enable_lag(enable_lag),
    .enable_approx(enable_approx), .enable_cancel(enable_cancel),
    .enable_out(enable_out), .double_out(double_out),
    .frame_done(frame_done), .frame_error(frame_error),
    .err_stage(err_stage), .frame_count(frame_count), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk_operation = ~clk_operation;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit          is_err;
    logic [1:0]  stage;
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] m_double = '0;
  logic        m_en_out = 1'b0;
  logic [15:0] m_count = '0;
  logic        exp_mode = 1'b0;
  int          approx_cyc = 0;
  int          cancel_cyc = 0;
  int          run_len[4];
  bit          stuck_lag = 1'b0;
  bit          rdy[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  bit          resp_prev[4];
  int          hold[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_done(input int at, input logic [63:0] val);
    exp_t x;
    x.is_err = 1'b0; x.stage = 2'd0; x.val = val; x.cyc = at;
    exp_q.push_back(x);
  endtask

  task automatic push_err(input int at, input logic [1:0] stage);
    exp_t x;
    x.is_err = 1'b1; x.stage = stage; x.val = '0; x.cyc = at;
    exp_q.push_back(x);
  endtask

  // ---------------- stage responders ----------------
  assign ready_conv   = rdy[0];
  assign ready_lag    = rdy[1];
  assign ready_approx = rdy[2];
  assign ready_cancel = rdy[3];

  always @(negedge clk_operation) begin
    logic en_v[4];
    en_v[0] = enable_conv;
    en_v[1] = enable_lag;
    en_v[2] = enable_approx;
    en_v[3] = enable_cancel;
    for (int s = 0; s < 4; s++) begin
      if (rst) begin
        rdy[s] = 1'b1;
        hold[s] = 0;
      end else if (resp_prev[s] && !en_v[s] && !(s == 1 && stuck_lag)) begin
        rdy[s] = 1'b0;
        hold[s] = HOLD;
      end else if (hold[s] > 0) begin
        hold[s]--;
        if (hold[s] == 0) rdy[s] = 1'b1;
      end
      resp_prev[s] = rst ? 1'b0 : en_v[s];
    end
  end

  // ---------------- compare process ----------------
  initial begin
    exp_t x;
    logic [3:0] en_v;
    forever begin
      @(posedge clk_operation);
      #1;
      cyc++;
      en_v = {enable_cancel, enable_approx, enable_lag, enable_conv};
      check("one_hot_enables", 64'($countones(en_v) <= 1), 64'd1);
      if (enable_approx || enable_cancel) check("branch_select", 64'(enable_approx), 64'(exp_mode));
      if (enable_approx) approx_cyc++;
      if (enable_cancel) cancel_cyc++;
      for (int s = 0; s < 4; s++) begin
        if (rst) run_len[s] = 0;
        else if (en_v[s]) run_len[s]++;
        else begin
          if (run_len[s] != 0) check("pulse_len", 64'(run_len[s]), 64'(PULSE_LEN));
          run_len[s] = 0;
        end
      end
      if (frame_done || frame_error) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_event: done=%b error=%b stage=%0d at cycle %0d, expected none",
                   frame_done, frame_error, err_stage, cyc);
        end else begin
          x = exp_q.pop_front();
          check("event_kind", {62'd0, frame_done, frame_error}, x.is_err ? 64'd1 : 64'd2);
          check("event_cycle", 64'(cyc), 64'(x.cyc));
          if (x.is_err) check("err_stage", 64'(err_stage), 64'(x.stage));
          else begin
            m_double = x.val;
            m_en_out = 1'b1;
            m_count  = m_count + 16'd1;
          end
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_event: no event by cycle %0d, expected %s at cycle %0d",
                 exp_q[0].cyc, exp_q[0].is_err ? "error" : "done", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      check("double_out", double_out, m_double);
      check("enable_out", 64'(enable_out), 64'(m_en_out));
      check("frame_count", 64'(frame_count), 64'(m_count));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input bit mode, input bit expect_done);
    adapt_mode = mode;
    exp_mode = mode;
    sampling_cycle_counter = '0;
    if (expect_done) push_done(cyc + LAT_NOM, mode ? e : signal_without_echo);
    @(negedge clk_operation);
    sampling_cycle_counter = CNT_RUN;
  endtask

  task automatic wait_events(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk_operation);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL event_timeout: %0d events pending after %0d cycles, expected 0",
               exp_q.size(), max_cycles);
      exp_q.delete();
    end
    @(negedge clk_operation);
  endtask

  task automatic wait_level(input int which, input bit level, input int max_cycles);
    int n = 0;
    logic v;
    v = (which == 0) ? enable_lag : enable_cancel;
    while (v !== level && n < max_cycles) begin
      @(negedge clk_operation);
      n++;
      v = (which == 0) ? enable_lag : enable_cancel;
    end
    check("wait_enable_level", 64'(v), 64'(level));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, a0, c0;
    rst = 1'b1;
    sampling_cycle_counter = CNT_RUN;
    adapt_mode = 1'b0;
    e = '0;
    signal_without_echo = '0;
    repeat (3) @(negedge clk_operation);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("rst_enables", 64'({enable_conv, enable_lag, enable_approx, enable_cancel}), 64'd0);
    check("rst_enable_out", 64'(enable_out), 64'd0);
    check("rst_double_out", double_out, 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_pulses", 64'({frame_done, frame_error}), 64'd0);
    rst = 1'b0;
    @(negedge clk_operation);

    // Adapt mode, nominal handshakes.
    e = 64'h3FF0_0000_0000_0000;
    signal_without_echo = 64'h1234_5678_9ABC_DEF0;
    start_frame(1'b1, 1'b1);
    wait_events(200);
    check("adapt_double_out", double_out, 64'h3FF0_0000_0000_0000);
    check("adapt_frame_count", 64'(frame_count), 64'd1);
    check("adapt_enable_out", 64'(enable_out), 64'd1);

    // Cancel mode, nominal handshakes.
    e = 64'h4000_0000_0000_0000;
    signal_without_echo = 64'hBFE0_0000_0000_0000;
    a0 = approx_cyc;
    c0 = cancel_cyc;
    start_frame(1'b0, 1'b1);
    wait_events(200);
    check("cancel_double_out", double_out, 64'hBFE0_0000_0000_0000);
    check("cancel_frame_count", 64'(frame_count), 64'd2);
    check("cancel_pulse_cycles", 64'(cancel_cyc - c0), 64'd2);
    check("cancel_no_approx", 64'(approx_cyc - a0), 64'd0);

    // Lag ready stuck high: the lag stage must time out.
    stuck_lag = 1'b1;
    e = 64'h7FF8_0000_0000_0000;
    t0 = cyc;
    start_frame(1'b1, 1'b0);
    push_err(t0 + 1 + PULSE_LEN + WAIT_NOM + PULSE_LEN + TO_LAG + 1, ERR_LAG);
    wait_events(400);
    check("stale_double_out", double_out, 64'hBFE0_0000_0000_0000);
    check("stale_frame_count", 64'(frame_count), 64'd2);
    check("stale_err_stage", 64'(err_stage), 64'd1);
    stuck_lag = 1'b0;

    // Overrun during the canceller wait; restart in adapt mode.
    signal_without_echo = 64'hC000_0000_0000_0000;
    start_frame(1'b0, 1'b0);
    wait_level(1, 1'b1, 100);
    wait_level(1, 1'b0, 10);
    repeat (3) @(negedge clk_operation);
    e = 64'h3FE0_0000_0000_0000;
    adapt_mode = 1'b1;
    exp_mode = 1'b1;
    sampling_cycle_counter = '0;
    push_err(cyc + 1, ERR_OVR);
    push_done(cyc + LAT_NOM, 64'h3FE0_0000_0000_0000);
    @(negedge clk_operation);
    sampling_cycle_counter = CNT_RUN;
    check("ovr_enable_conv", 64'(enable_conv), 64'd1);
    check("ovr_frame_error", 64'(frame_error), 64'd1);
    check("ovr_err_stage", 64'(err_stage), 64'd3);
    check("ovr_frame_count", 64'(frame_count), 64'd2);
    wait_events(200);
    check("ovr_new_double_out", double_out, 64'h3FE0_0000_0000_0000);
    check("ovr_new_frame_count", 64'(frame_count), 64'd3);

    // Reset while the lag enable is high.
    start_frame(1'b1, 1'b0);
    wait_level(0, 1'b1, 100);
    rst = 1'b1;
    m_double = '0;
    m_en_out = 1'b0;
    m_count = '0;
    exp_q.delete();
    @(negedge clk_operation);
    check("midrst_enables", 64'({enable_conv, enable_lag, enable_approx, enable_cancel}), 64'd0);
    check("midrst_enable_out", 64'(enable_out), 64'd0);
    check("midrst_double_out", double_out, 64'd0);
    check("midrst_state", 64'(state_dbg), 64'(ST_IDLE));
    check("midrst_frame_count", 64'(frame_count), 64'd0);
    rst = 1'b0;
    @(negedge clk_operation);

    // Counter wrap with adapt_mode toggled mid-frame.
    force dut.frame_count = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge clk_operation);
    release dut.frame_count;
    @(negedge clk_operation);
    e = 64'h4008_0000_0000_0000;
    signal_without_echo = 64'hC008_0000_0000_0000;
    start_frame(1'b1, 1'b1);
    repeat (5) @(negedge clk_operation);
    adapt_mode = 1'b0;
    wait_events(200);
    check("wrap_frame_count", 64'(frame_count), 64'd0);
    check("latch_double_out", double_out, 64'h4008_0000_0000_0000);
    check("wrap_enable_out", 64'(enable_out), 64'd1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
